// File: rtl/cordic_pkg.sv
// cordic_pkg: mode encoding, gain-compensation constant and atan table generator
// shared by the CORDIC engine and its micro-rotation stages.
package cordic_pkg;
    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;
    localparam int GAIN_SH = 17;
    localparam logic signed [GAIN_SH:0] GAIN_COMP = 18'sd79595;
    localparam logic [127:0] PI_4 = 128'hC90FDAA22168C235;
    // atan(2^-i) as a fraction of the full circle 2^zw, rounded; valid for i < 32
    function automatic logic [31:0] atan_tab(input int i, input int zw);
        logic [127:0] acc, term;
        if (i == 0) return 32'd1 << (zw - 3);
        acc = '0;
        for (int k = 1; k * i < 64; k += 2) begin
            term = (128'd1 << (64 - k * i)) / 128'(k);
            acc = k[1] ? acc - term : acc + term;
        end
        return 32'(((acc << (zw - 2)) / PI_4 + 128'd1) >> 1);
    endfunction
endpackage

// File: rtl/cordic_stage.sv
// cordic_stage: one registered CORDIC micro-rotation with shift index I,
// carrying the valid bit and mode tag alongside the data.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int W  = 27,
    parameter int ZW = 30,
    parameter int I  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic                 in_mode,
    input  logic signed [W-1:0]  xi,
    input  logic signed [W-1:0]  yi,
    input  logic signed [ZW-1:0] zi,
    output logic                 out_valid,
    output logic                 out_mode,
    output logic signed [W-1:0]  xo,
    output logic signed [W-1:0]  yo,
    output logic signed [ZW-1:0] zo
);
    localparam logic signed [ZW-1:0] AT = ZW'(atan_tab(I, ZW));
    logic up;
    assign up = (in_mode == MODE_VEC) ? yi[W-1] : ~zi[ZW-1];
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            out_valid <= 1'b0;
            out_mode  <= 1'b0;
            xo        <= '0;
            yo        <= '0;
            zo        <= '0;
        end else if (ce) begin
            out_valid <= in_valid;
            out_mode  <= in_mode;
            xo        <= up ? xi - (yi >>> I) : xi + (yi >>> I);
            yo        <= up ? yi + (xi >>> I) : yi - (xi >>> I);
            zo        <= up ? zi - AT : zi + AT;
        end
endmodule

// File: rtl/cordic_pipe_engine.sv
// cordic_pipe_engine: fully pipelined rotation/vectoring CORDIC with quadrant pre-rotation.
// Defining CORDIC_GAIN_COMP_EN adds a registered 1/K scaling stage (one extra cycle of latency).
module cordic_pipe_engine
    import cordic_pkg::*;
#(
    parameter int DW     = 25,
    parameter int ZW     = 30,
    parameter int NSTAGE = 18,
    parameter int OW     = DW + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic                 in_mode,
    input  logic signed [DW-1:0] xi,
    input  logic signed [DW-1:0] yi,
    input  logic signed [ZW-1:0] zi,
    output logic                 out_valid,
    output logic                 out_mode,
    output logic signed [OW-1:0] xo,
    output logic signed [OW-1:0] yo,
    output logic signed [ZW-1:0] zo
);
    logic signed [OW-1:0] xs [NSTAGE+1];
    logic signed [OW-1:0] ys [NSTAGE+1];
    logic signed [ZW-1:0] zs [NSTAGE+1];
    logic                 vs [NSTAGE+1];
    logic                 ms [NSTAGE+1];
    logic signed [OW-1:0] xe, ye, xp, yp;
    logic signed [ZW-1:0] zp;
    logic                 vp, mp, flip;
    assign xe = {{(OW-DW){xi[DW-1]}}, xi};
    assign ye = {{(OW-DW){yi[DW-1]}}, yi};
    // a half-turn flip brings every input into the stages' +/-90 deg convergence range
    assign flip = (in_mode == MODE_VEC) ? xi[DW-1] : zi[ZW-1] ^ zi[ZW-2];
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            vp <= 1'b0;
            mp <= 1'b0;
            xp <= '0;
            yp <= '0;
            zp <= '0;
        end else if (ce) begin
            vp <= in_valid;
            mp <= in_mode;
            xp <= flip ? -xe : xe;
            yp <= flip ? -ye : ye;
            zp <= {zi[ZW-1] ^ flip, zi[ZW-2:0]};
        end
    assign xs[0] = xp;
    assign ys[0] = yp;
    assign zs[0] = zp;
    assign vs[0] = vp;
    assign ms[0] = mp;
    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        cordic_stage #(.W(OW), .ZW(ZW), .I(k)) u_stage (
            .clk(clk), .rst(rst), .ce(ce),
            .in_valid(vs[k]), .in_mode(ms[k]), .xi(xs[k]), .yi(ys[k]), .zi(zs[k]),
            .out_valid(vs[k+1]), .out_mode(ms[k+1]), .xo(xs[k+1]), .yo(ys[k+1]), .zo(zs[k+1])
        );
    end
`ifdef CORDIC_GAIN_COMP_EN
    logic signed [OW+GAIN_SH:0] px, py;
    assign px = (OW+GAIN_SH+1)'(xs[NSTAGE]) * (OW+GAIN_SH+1)'(GAIN_COMP);
    assign py = (OW+GAIN_SH+1)'(ys[NSTAGE]) * (OW+GAIN_SH+1)'(GAIN_COMP);
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            out_valid <= 1'b0;
            out_mode  <= 1'b0;
            xo        <= '0;
            yo        <= '0;
            zo        <= '0;
        end else if (ce) begin
            out_valid <= vs[NSTAGE];
            out_mode  <= ms[NSTAGE];
            xo        <= OW'(px >>> GAIN_SH);
            yo        <= OW'(py >>> GAIN_SH);
            zo        <= zs[NSTAGE];
        end
`else
    assign out_valid = vs[NSTAGE];
    assign out_mode  = ms[NSTAGE];
    assign xo        = xs[NSTAGE];
    assign yo        = ys[NSTAGE];
    assign zo        = zs[NSTAGE];
`endif
endmodule

// File: tb/tb_cordic_pipe_engine.sv
// tb_cordic_pipe_engine: randomized scoreboard bench; expected results come from
// floating-point trigonometry scaled by the finite-stage CORDIC gain.
module tb_cordic_pipe_engine;
    localparam int DW = 25;
    localparam int ZW = 30;
    localparam int N  = 18;
    localparam int OW = DW + 2;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT = N + 2;
`else
    localparam int LAT = N + 1;
`endif
    localparam real PI = 3.14159265358979323846;
    localparam real FULL = 2.0 ** ZW;

    logic clk = 1'b0, rst = 1'b0, ce = 1'b0, in_valid = 1'b0, in_mode = 1'b0;
    logic signed [DW-1:0] xi = '0, yi = '0;
    logic signed [ZW-1:0] zi = '0;
    logic out_valid, out_mode;
    logic signed [OW-1:0] xo, yo;
    logic signed [ZW-1:0] zo;

    cordic_pipe_engine #(.DW(DW), .ZW(ZW), .NSTAGE(N), .OW(OW)) dut (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_mode(in_mode),
        .xi(xi), .yi(yi), .zi(zi),
        .out_valid(out_valid), .out_mode(out_mode), .xo(xo), .yo(yo), .zo(zo)
    );

    always #5 clk = ~clk;

    typedef struct {int x; int y; int z; bit m; int issue;} ent_t;
    ent_t q[$];
    int cyc = 0, cmp = 0, bad = 0;
    logic [2*OW+ZW+1:0] prev = '0;

    function automatic real kgain();
        real k = 1.0;
        for (int i = 0; i < N; i++) k = k * $sqrt(1.0 + 2.0 ** (-2.0 * i));
`ifdef CORDIC_GAIN_COMP_EN
        k = k * 79595.0 / 131072.0;
`endif
        return k;
    endfunction

    task automatic chk(input string nm, input real act, input real exp, input real tol, input real wrap);
        real d;
        d = act - exp;
        if (wrap > 0.0) begin
            while (d >= wrap / 2.0) d = d - wrap;
            while (d < -wrap / 2.0) d = d + wrap;
        end
        cmp++;
        if (d > tol || d < -tol) begin
            bad++;
            $display("FAIL %s: got %0.1f want %0.1f (tol %0.1f)", nm, act, exp, tol);
        end
    endtask

    task automatic check_out();
        ent_t e;
        logic signed [ZW-1:0] zz;
        real u, r, res, kk, th, ex, ey, ez, txy, tz;
        if (q.size() == 0) begin
            cmp++;
            bad++;
            $display("FAIL unexpected_valid: out_valid got 1 want 0 (nothing pending)");
            return;
        end
        e = q.pop_front();
        chk("latency", real'(cyc - e.issue), real'(LAT), 0.0, 0.0);
        chk("out_mode", real'(out_mode), real'(e.m), 0.0, 0.0);
        zz = ZW'(e.z);
        u = FULL / (2.0 * PI);
        r = $sqrt(real'(e.x) * e.x + real'(e.y) * e.y);
        res = $atan(2.0 ** (1 - N));
        kk = kgain();
        txy = 2.0 * N + 2.0 * kk * r * res;
        if (!e.m) begin
            th = real'(zz) / u;
            ex = kk * (e.x * $cos(th) - e.y * $sin(th));
            ey = kk * (e.x * $sin(th) + e.y * $cos(th));
            ez = 0.0;
            tz = 64.0 + 2.0 * res * u;
        end else begin
            ex = kk * r;
            ey = 0.0;
            ez = real'(zz) + $atan2(real'(e.y), real'(e.x)) * u;
            tz = 64.0 + (2.0 * res + 4.0 * N / (r + 1.0)) * u;
        end
        chk("xo", real'(xo), ex, txy, 0.0);
        chk("yo", real'(yo), ey, txy, 0.0);
        if (!(e.m && r == 0.0)) chk("zo", real'(zo), ez, tz, FULL);
    endtask

    always @(posedge clk) begin
        bit c_s, r_s;
        c_s = ce;
        r_s = rst;
        #1;
        if (r_s && rst) begin
            if (c_s) begin
                cyc++;
                if (out_valid) check_out();
            end else begin
                cmp++;
                if ({out_valid, out_mode, xo, yo, zo} != prev) begin
                    bad++;
                    $display("FAIL ce_hold: got %h want %h", {out_valid, out_mode, xo, yo, zo}, prev);
                end
            end
        end
        prev = {out_valid, out_mode, xo, yo, zo};
    end

    task automatic drive(input bit v, input bit m, input int x, input int y, input int z, input bit c);
        @(negedge clk);
        ce = c;
        in_valid = v;
        in_mode = m;
        xi = DW'(x);
        yi = DW'(y);
        zi = ZW'(z);
        if (c && v) q.push_back('{x, y, z, m, cyc});
    endtask

    task automatic rnd(input bit gaps);
        bit m, v, c;
        int x, y, z;
        m = 1'($urandom_range(1, 0));
        v = $urandom_range(9, 0) != 0;
        c = gaps ? ($urandom_range(6, 0) != 0) : 1'b1;
        x = int'($urandom) >>> 7;
        y = int'($urandom) >>> 7;
        z = int'($urandom) >>> 2;
        if (m && x > -(1 << 20) && x < (1 << 20) && y > -(1 << 20) && y < (1 << 20))
            x = (x < 0) ? x - (1 << 20) : x + (1 << 20);
        drive(v, m, x, y, z, c);
    endtask

    task automatic directed();
        drive(1, 0, 4194304, 0, 1 << 27, 1);
        drive(1, 1, 3000000, 4000000, 0, 1);
        drive(1, 0, 4194304, 0, 1 << 29, 1);
        drive(1, 1, -3000000, 0, 0, 1);
        drive(1, 1, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_xo"}, real'(xo), 0.0, 0.0, 0.0);
        chk({tag, "_yo"}, real'(yo), 0.0, 0.0, 0.0);
        chk({tag, "_zo"}, real'(zo), 0.0, 0.0, 0.0);
        chk({tag, "_valid"}, real'(out_valid), 0.0, 0.0, 0.0);
        chk({tag, "_mode"}, real'(out_mode), 0.0, 0.0, 0.0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        directed();
        for (int i = 0; i < 400; i++) rnd(1'b1);
        for (int i = 0; i < 10; i++) drive(1, i[0], 1000000 + i * 1000, 2000000, i << 24, 1);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk_zero("midreset");
        q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        directed();
        for (int i = 0; i < 200; i++) rnd(1'b1);
        for (int i = 0; i < 200 && q.size() > 0; i++) drive(0, 0, 0, 0, 0, 1);
        repeat (2) drive(0, 0, 0, 0, 0, 1);
        chk("drain", real'(q.size()), 0.0, 0.0, 0.0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule

// File: doc/cordic_pipe_engine.md
Name: cordic_pipe_engine

Overview:
Fully pipelined, parametrised CORDIC core for the DDC datapath. Supports rotation mode (polar->rectangular / NCO mixing) and vectoring mode (rectangular->polar / magnitude-phase), selected per sample.
- Includes quadrant pre-rotation for full-circle coverage, a valid/clock-enable pipeline, and a mode tag carried alongside each sample.
- Sits between the fir_4mux1 decimator outputs and the downstream phase/AGC logic.

Parameters:
DW, 25, input x/y width (signed two's complement)
ZW, 30, angle width; full circle = 2^ZW, so 45 deg = 2^(ZW-3)
NSTAGE, 18, micro-rotation stage count, legal range 1..ZW-2
OW, DW+2, output x/y width; 2 guard bits absorb CORDIC gain K~1.6468 and quadrant negation

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
ce  in  1  clock enable; 0 freezes the whole pipeline, including valid bits
in_valid  in  1  input sample qualifier
in_mode  in  1  0 = rotation (drive z->0), 1 = vectoring (drive y->0)
xi  in  DW  signed x
yi  in  DW  signed y
zi  in  ZW  signed angle
out_valid  out  1  output qualifier
out_mode  out  1  mode tag aligned with outputs
xo  out  OW  signed x result
yo  out  OW  signed y result
zo  out  ZW  signed angle result

Behaviour:
- Reset: while rst=0, all pipeline registers clear asynchronously. xo=0, yo=0, zo=0, out_valid=0, out_mode=0.
- Reset mid-stream: all in-flight samples are discarded. The first out_valid after release is the first sample accepted after release, exactly LAT cycles later.
- Latency: LAT = NSTAGE+1 ce-qualified cycles (1 pre-rotation register + NSTAGE stages). Throughput is 1 sample per ce cycle; there is no backpressure.
- ce=0: no register updates and outputs hold. Inputs presented during ce=0 are ignored.
- Invalid samples: registers still advance (bubbles propagate) and out_valid tracks in_valid delayed by LAT. Data registers of invalid slots may hold anything, but outputs hold their last valid value only when ce=0.
- Input sign extension: xi/yi are sign-extended to OW before any operation.
- Pre-rotation, rotation mode: if zi[ZW-1:ZW-2] is 01 or 10 (|z| > 90 deg), then x=-x, y=-y, z=z+2^(ZW-1) with modulo-2^ZW wrap. Otherwise pass through.
- Pre-rotation, vectoring mode: if x<0, then x=-x, y=-y, z=zi+2^(ZW-1) with wrap. Otherwise pass through.
- Stage i (i=0..NSTAGE-1), direction d:
  - Rotation mode: d=+1 if z>=0, else -1.
  - Vectoring mode: d=+1 if y<0, else -1.
  - Update: x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*atan_i.
  - Shifts are arithmetic. Adds wrap modulo 2^OW (x/y) and 2^ZW (z). No saturation.
- atan_i = round(atan(2^-i) * 2^ZW / (2*pi)). For ZW=30: atan_0 = 0x08000000, atan_1 = 0x04B90147.
- Mode tag and valid bit travel in a shift register of depth LAT, under the same ce.
- Outputs are unscaled, i.e. carry gain K, unless the optional feature is enabled.
- Edge case xi=yi=0 in vectoring mode: output z is don't-care, x=y=0.

Optional Feature:
CORDIC_GAIN_COMP_EN
- Defined: one extra registered stage multiplies x and y by round(2^17/K) = 79595, then applies arithmetic shift right by 17. LAT = NSTAGE+2; z and the mode tag are delayed by one extra cycle to stay aligned.
- Undefined: no multiplier, LAT = NSTAGE+1, outputs carry gain K.

Decomposition:
- Package cordic_pkg holds:
  - the atan table as a function/constant array of ZW-wide values, generated for up to 32 entries;
  - the mode encoding constants MODE_ROT=0 and MODE_VEC=1;
  - the gain-compensation constant.
- Sub-module cordic_stage: one registered micro-rotation, parameterised by width, stage index and ZW, with ports for x, y, z, mode, valid and ce.
- The engine instantiates the pre-rotation stage plus NSTAGE instances of cordic_stage in a generate loop.

Test Plan (DW=25, ZW=30, NSTAGE=18, feature off; tolerance +/-NSTAGE LSB on x/y, +/-64 LSB on z):
- Rotation, xi=4194304, yi=0, zi=2^27 (45 deg) -> after 19 cycles: xo ~= yo ~= 4883978, zo ~= 0, out_mode=0.
- Vectoring, xi=3000000, yi=4000000, zi=0 -> xo ~= 8233800, yo ~= 0, zo ~= 158466684 (53.13 deg).
- Quadrant handling:
  - Rotation with zi=2^29 (180 deg), xi=4194304 -> xo ~= -6906974, yo ~= 0.
  - Vectoring with xi=-3000000, yi=0 -> xo ~= 4940280, |zo| ~= 2^29.
- Streaming: back-to-back valid samples with alternating mode, including bubbles and random ce=0 gaps -> each result is correct, mode-tagged, and out_valid follows in_valid delayed by exactly 19 ce cycles.
- Reset mid-stream: assert rst=0 with 10 samples in flight -> outputs 0 immediately. After release, no stale out_valid; the first new sample appears 19 cycles later.
- With CORDIC_GAIN_COMP_EN defined: repeat scenario 1 -> xo ~= yo ~= 2965821, latency 20 cycles.
